// File: rtl/arbiter_rr.sv
// arbiter_rr: NUM_REQ-way arbiter, fixed-priority or round-robin, with hold-limit handoff
//   clock     rising-edge clock
//   reset     asynchronous active-high reset
//   req       request vector, bit i = requester i
//   rr_en     1 = round-robin from ptr, 0 = fixed priority (index 0 highest)
//   gnt       registered one-hot grant, zero when idle
//   gnt_id    index of current owner, 0 when idle
//   gnt_valid high whenever a grant bit is set
//   forced    one-cycle pulse marking a grant produced by a hold-limit handoff
module arbiter_rr #(
    parameter int NUM_REQ = 4,
    parameter int MAX_HOLD = 8,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               rr_en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               forced
);
    localparam int HC_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic [1:0] {IDLE = 2'b01, GRANT = 2'b10} state_t;

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [HC_W-1:0]    hold_cnt;
    logic [NUM_REQ-1:0] others;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] win_oh;
    logic [ID_W-1:0]    win;
    logic [ID_W-1:0]    win_next;
    logic               owner_req;
    logic               limit;

    // Highest-priority set bit of v: lowest index, or first index at/after p (wrapping) in rr mode.
    function automatic logic [ID_W-1:0] pick(input logic [NUM_REQ-1:0] v,
                                             input logic [ID_W-1:0] p,
                                             input logic rr);
        logic [ID_W-1:0] w;
        int j;
        w = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = rr ? int'(p) + k : k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (j < NUM_REQ && v[ID_W'(j)]) w = ID_W'(j);
        end
        return w;
    endfunction

    assign others    = req & ~gnt;
    assign owner_req = |(req & gnt);
    assign limit     = (MAX_HOLD != 0) && (|others) && (hold_cnt == HOLD_LAST);
    // A forced handoff masks the owner; on a drop or from idle req already excludes it.
    assign cand      = (owner_req && limit) ? others : req;
    assign win       = pick(cand, ptr, rr_en);
    assign win_oh    = NUM_REQ'(1) << win;
    assign win_next  = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            forced    <= 1'b0;
            hold_cnt  <= '0;
            ptr       <= '0;
        end else begin
            forced <= 1'b0;
            case (state)
                IDLE, GRANT: begin
                    if (state == GRANT && owner_req && !limit) begin
                        // Count only contended cycles; an uncontended cycle restarts the window.
                        hold_cnt <= (|others) ? ((hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1) : '0;
                    end else if (|cand) begin
                        state     <= GRANT;
                        gnt       <= win_oh;
                        gnt_id    <= win;
                        gnt_valid <= 1'b1;
                        ptr       <= win_next;
                        hold_cnt  <= '0;
                        // Owner still requesting here means the limit forced the change.
                        forced    <= (state == GRANT) && owner_req;
                    end else begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_id    <= '0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_id    <= '0;
                    gnt_valid <= 1'b0;
                    hold_cnt  <= '0;
                end
            endcase
        end
    end

    a_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(gnt));
    a_valid:  assert property (@(posedge clock) disable iff (reset) gnt_valid == (|gnt));
    a_id:     assert property (@(posedge clock) disable iff (reset)
                               gnt_valid ? gnt[gnt_id] : (gnt_id == '0));
endmodule

// File: tb/tb_arbiter_rr.sv
// tb_arbiter_rr: directed table, corner sequences and random checks of arbiter_rr against a reference model
module tb_arbiter_rr;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0;
    logic       rr_en = 1'b0;
    logic [3:0] gnt_o [2];
    logic [1:0] id_o [2];
    logic       val_o [2];
    logic       frc_o [2];
    int n_tests = 0;
    int n_fail = 0;

    arbiter_rr #(.NUM_REQ(4), .MAX_HOLD(0)) dut0 (
        .clock(clk), .reset(reset), .req(req), .rr_en(rr_en),
        .gnt(gnt_o[0]), .gnt_id(id_o[0]), .gnt_valid(val_o[0]), .forced(frc_o[0]));
    arbiter_rr #(.NUM_REQ(4), .MAX_HOLD(8)) dut8 (
        .clock(clk), .reset(reset), .req(req), .rr_en(rr_en),
        .gnt(gnt_o[1]), .gnt_id(id_o[1]), .gnt_valid(val_o[1]), .forced(frc_o[1]));

    always #5 clk = ~clk;

    // Reference model: owner as an integer (-1 = idle), rotation start, contended-cycle count.
    int m_own [2] = '{-1, -1};
    int m_ptr [2] = '{0, 0};
    int m_hold [2] = '{0, 0};
    bit m_forced [2] = '{1'b0, 1'b0};
    int mo, mw;
    bit moth;

    function automatic int mh(int d);
        return (d == 0) ? 0 : 8;
    endfunction

    function automatic int pick(logic [3:0] v, int p, bit rr);
        int i;
        for (int k = 0; k < 4; k++) begin
            i = rr ? (p + k) % 4 : k;
            if (v[2'(i)]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                m_own[d] = -1; m_ptr[d] = 0; m_hold[d] = 0; m_forced[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                mo = m_own[d];
                moth = (mo < 0) ? (req != 4'b0) : ((req & ~(4'b1 << mo)) != 4'b0);
                m_forced[d] = 1'b0;
                mw = -2;
                if (mo >= 0 && req[2'(mo)]) begin
                    if (mh(d) != 0 && moth && m_hold[d] == mh(d) - 1) begin
                        mw = pick(req & ~(4'b1 << mo), m_ptr[d], rr_en);
                        m_forced[d] = 1'b1;
                    end else begin
                        m_hold[d] = moth ? ((m_hold[d] < 1000) ? m_hold[d] + 1 : m_hold[d]) : 0;
                    end
                end else begin
                    mw = pick(req, m_ptr[d], rr_en);
                end
                if (mw == -1) begin
                    m_own[d] = -1; m_hold[d] = 0;
                end else if (mw >= 0) begin
                    m_own[d] = mw; m_ptr[d] = (mw + 1) % 4; m_hold[d] = 0;
                end
            end
        end
    end

    function automatic logic [7:0] expect_of(int own, bit f);
        logic [3:0] g;
        g = (own < 0) ? 4'b0 : 4'b1 << own;
        return {g, (own < 0) ? 2'd0 : 2'(own), |g, f};
    endfunction

    function automatic logic [7:0] pack_dut(int d);
        return {gnt_o[d], id_o[d], val_o[d], frc_o[d]};
    endfunction

    task automatic cmp(string name, logic [7:0] act, logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: {gnt,id,valid,forced} got %b_%b_%b_%b expected %b_%b_%b_%b",
                     name, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic check_models();
        cmp("model_mh0", pack_dut(0), expect_of(m_own[0], m_forced[0]));
        cmp("model_mh8", pack_dut(1), expect_of(m_own[1], m_forced[1]));
    endtask

    task automatic step(logic [3:0] r, logic rr);
        req = r;
        rr_en = rr;
        @(posedge clk);
        @(negedge clk);
        check_models();
    endtask

    typedef struct {
        logic [3:0] req;
        logic       rr;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       f;
    } vec_t;
    vec_t tbl [19];

    initial begin
        logic [3:0] r;
        tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{4'b1110, 1'b0, 4'b0010, 2'd1, 1'b0};
        tbl[2]  = '{4'b1110, 1'b0, 4'b0010, 2'd1, 1'b0};
        tbl[3]  = '{4'b1110, 1'b0, 4'b0010, 2'd1, 1'b0};
        tbl[4]  = '{4'b1100, 1'b0, 4'b0100, 2'd2, 1'b0};
        tbl[5]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[6]  = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0};
        tbl[7]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0};
        tbl[10] = '{4'b1110, 1'b1, 4'b0010, 2'd1, 1'b0};
        tbl[11] = '{4'b1101, 1'b1, 4'b0100, 2'd2, 1'b0};
        tbl[12] = '{4'b1011, 1'b1, 4'b1000, 2'd3, 1'b0};
        tbl[13] = '{4'b0111, 1'b1, 4'b0001, 2'd0, 1'b0};
        tbl[14] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        tbl[15] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b0};
        tbl[16] = '{4'b0101, 1'b0, 4'b0100, 2'd2, 1'b0};
        tbl[17] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0};
        tbl[18] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};

        repeat (2) @(negedge clk);
        cmp("reset_mh0", pack_dut(0), 8'b0);
        cmp("reset_mh8", pack_dut(1), 8'b0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].req, tbl[i].rr);
            cmp($sformatf("vec%0d", i), pack_dut(0), {tbl[i].gnt, tbl[i].id, |tbl[i].gnt, tbl[i].f});
        end

        step(4'b0001, 1'b1);
        cmp("hold_start", pack_dut(1), expect_of(0, 1'b0));
        for (int k = 1; k <= 7; k++) begin
            step(4'b0101, 1'b1);
            cmp($sformatf("hold_keep%0d", k), pack_dut(1), expect_of(0, 1'b0));
        end
        step(4'b0101, 1'b1);
        cmp("hold_forced", pack_dut(1), expect_of(2, 1'b1));
        cmp("hold_nolimit", pack_dut(0), expect_of(0, 1'b0));
        step(4'b0101, 1'b1);
        cmp("hold_pulse_end", pack_dut(1), expect_of(2, 1'b0));
        step(4'b0001, 1'b1);
        cmp("hold_regain", pack_dut(1), expect_of(0, 1'b0));
        for (int k = 1; k <= 7; k++) step(4'b0101, 1'b1);
        cmp("drop_pre", pack_dut(1), expect_of(0, 1'b0));
        step(4'b0100, 1'b1);
        cmp("drop_at_limit", pack_dut(1), expect_of(2, 1'b0));

        step(4'b0010, 1'b1);
        reset = 1'b1;
        #1;
        cmp("rst_async_mh0", pack_dut(0), 8'b0);
        cmp("rst_async_mh8", pack_dut(1), 8'b0);
        #2 reset = 1'b0;
        step(4'b0010, 1'b1);
        cmp("rst_release", pack_dut(0), expect_of(1, 1'b0));

        r = 4'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            if ($urandom_range(0, 9) == 0) rr_en = ~rr_en;
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                #1 reset = 1'b0;
            end
            step(r, rr_en);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion before 200000");
        $fatal(1);
    end
endmodule
